// File: rtl/dispatch_buffer.sv
// dispatch_buffer: instruction FIFO between the fetcher and the ROB/RS/LSB.
// Each cycle the head entry is decoded, its two source operands are resolved
// through register file -> ROB -> CDB bypass, and it is dispatched to either
// the RS or the LSB with a freshly allocated ROB tag.
//
// Ports
//   clk, rst (async, active-low), rdy (global enable), flush (clear FIFO)
//   fetch_*        : enqueue handshake, instruction/PC/predicted-taken
//   reg_*          : register file lookup for the head's rs1/rs2
//   rob_q_*        : ROB result lookup keyed by the register file tags
//   rob_free_tag, rob_full, rs_full, lsb_full : allocation status
//   cdb_*          : CDB_N broadcast channels, packed channel-major
//   disp_*         : dispatch bundle, valid for one cycle, zero when idle
//   ren_*          : rename request for the destination register
//   count          : FIFO occupancy
module dispatch_buffer #(
    parameter  int DEPTH = 8,
    parameter  int XLEN  = 32,
    parameter  int ROB_W = 4,
    parameter  int CDB_N = 2,
    localparam int OP_W  = 6,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic [31:0]              fetch_inst,
    input  logic [XLEN-1:0]          fetch_pc,
    input  logic                     fetch_pred,
    output logic [4:0]               reg_rs1,
    output logic [4:0]               reg_rs2,
    input  logic [XLEN-1:0]          reg_val1,
    input  logic [XLEN-1:0]          reg_val2,
    input  logic                     reg_busy1,
    input  logic                     reg_busy2,
    input  logic [ROB_W-1:0]         reg_tag1,
    input  logic [ROB_W-1:0]         reg_tag2,
    output logic [ROB_W-1:0]         rob_q_tag1,
    output logic [ROB_W-1:0]         rob_q_tag2,
    input  logic                     rob_q_ready1,
    input  logic                     rob_q_ready2,
    input  logic [XLEN-1:0]          rob_q_val1,
    input  logic [XLEN-1:0]          rob_q_val2,
    input  logic [ROB_W-1:0]         rob_free_tag,
    input  logic                     rob_full,
    input  logic                     rs_full,
    input  logic                     lsb_full,
    input  logic [CDB_N-1:0]         cdb_valid,
    input  logic [CDB_N*ROB_W-1:0]   cdb_tag,
    input  logic [CDB_N*XLEN-1:0]    cdb_val,
    output logic                     disp_valid,
    output logic                     disp_to_rs,
    output logic                     disp_to_lsb,
    output logic [OP_W-1:0]          disp_op,
    output logic [XLEN-1:0]          disp_imm,
    output logic [XLEN-1:0]          disp_pc,
    output logic [4:0]               disp_rd,
    output logic                     disp_pred,
    output logic [XLEN-1:0]          disp_val1,
    output logic [XLEN-1:0]          disp_val2,
    output logic [ROB_W-1:0]         disp_tag1,
    output logic [ROB_W-1:0]         disp_tag2,
    output logic [ROB_W-1:0]         disp_rob_tag,
    output logic                     ren_valid,
    output logic [4:0]               ren_rd,
    output logic [ROB_W-1:0]         ren_tag,
    output logic [CNT_W-1:0]         count
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0]      inst_q [DEPTH];
    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic             pred_q [DEPTH];
    logic [PTR_W-1:0] head, tail;

    logic             have_head, push, pop, disp_go, drop_go, active;
    logic [31:0]      head_inst;
    logic [6:0]       opcode;
    logic             is_lsb, is_drop, tgt_full, use_op1, use_op2;
    logic [OP_W-1:0]  dec_op;
    logic [4:0]       dec_rd, dec_rs1, dec_rs2, rd_eff;
    logic [31:0]      dec_imm;
    logic [XLEN-1:0]  opnd_val1, opnd_val2;
    logic [ROB_W-1:0] opnd_tag1, opnd_tag2;

    // Empty FIFO presents an all-zero head so lookups and outputs stay quiet.
    assign have_head = (count != '0);
    assign head_inst = have_head ? inst_q[head] : 32'h0;
    assign opcode    = head_inst[6:0];

    decodeunit u_dec (
        .inst (head_inst),
        .op   (dec_op),
        .rd   (dec_rd),
        .rs1  (dec_rs1),
        .rs2  (dec_rs2),
        .imm  (dec_imm)
    );

    assign reg_rs1    = dec_rs1;
    assign reg_rs2    = dec_rs2;
    assign rob_q_tag1 = reg_tag1;
    assign rob_q_tag2 = reg_tag2;

    // Memory opcodes always go to the LSB, even if the funct3 is not a legal
    // access width; only non-memory NOPs are silently discarded.
    assign is_lsb   = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    assign is_drop  = !is_lsb && (dec_op == '0);
    assign tgt_full = is_lsb ? lsb_full : rs_full;

    assign active      = rdy && !flush && have_head;
    assign disp_go     = active && !is_drop && !rob_full && !tgt_full;
    assign drop_go     = active && is_drop;
    assign pop         = disp_go || drop_go;
    assign fetch_ready = rst && rdy && !flush && (count < CNT_W'(DEPTH));
    assign push        = fetch_valid && fetch_ready;

    assign use_op1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    assign use_op2 = (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);
    assign rd_eff  = ((opcode == OPC_STORE) || (opcode == OPC_BRANCH)) ? 5'd0 : dec_rd;

    // Register file -> ROB -> CDB bypass. Returns {value, tag}; a nonzero tag
    // means the operand is still pending on that ROB entry.
    function automatic logic [XLEN+ROB_W-1:0] resolve(
        input logic [4:0]             rs,
        input logic                   busy,
        input logic [XLEN-1:0]        rval,
        input logic [ROB_W-1:0]       rtag,
        input logic                   qrdy,
        input logic [XLEN-1:0]        qval,
        input logic [CDB_N-1:0]       cv,
        input logic [CDB_N*ROB_W-1:0] ct,
        input logic [CDB_N*XLEN-1:0]  cd
    );
        logic             hit;
        logic [XLEN-1:0]  v;
        logic [ROB_W-1:0] t;
        hit = 1'b0;
        v   = '0;
        t   = '0;
        if (rs == 5'd0) begin
            v = '0;
        end else if (!busy) begin
            v = rval;
        end else if (qrdy) begin
            v = qval;
        end else begin
            // Lowest-numbered matching channel wins.
            for (int k = 0; k < CDB_N; k++) begin
                if (!hit && cv[k] && (ct[k*ROB_W +: ROB_W] == rtag)) begin
                    hit = 1'b1;
                    v   = cd[k*XLEN +: XLEN];
                end
            end
            if (!hit) t = rtag;
        end
        return {v, t};
    endfunction

    always_comb begin
        {opnd_val1, opnd_tag1} = resolve(dec_rs1, reg_busy1, reg_val1, reg_tag1,
                                         rob_q_ready1, rob_q_val1, cdb_valid, cdb_tag, cdb_val);
        {opnd_val2, opnd_tag2} = resolve(dec_rs2, reg_busy2, reg_val2, reg_tag2,
                                         rob_q_ready2, rob_q_val2, cdb_valid, cdb_tag, cdb_val);
        if (!use_op1) begin
            opnd_val1 = '0;
            opnd_tag1 = '0;
        end
        if (!use_op2) begin
            opnd_val2 = '0;
            opnd_tag2 = '0;
        end
    end

    always_comb begin
        disp_valid   = 1'b0;
        disp_to_rs   = 1'b0;
        disp_to_lsb  = 1'b0;
        disp_op      = '0;
        disp_imm     = '0;
        disp_pc      = '0;
        disp_rd      = '0;
        disp_pred    = 1'b0;
        disp_val1    = '0;
        disp_val2    = '0;
        disp_tag1    = '0;
        disp_tag2    = '0;
        disp_rob_tag = '0;
        ren_valid    = 1'b0;
        ren_rd       = '0;
        ren_tag      = '0;
        if (disp_go) begin
            disp_valid   = 1'b1;
            disp_to_rs   = !is_lsb;
            disp_to_lsb  = is_lsb;
            disp_op      = dec_op;
            disp_imm     = XLEN'($signed(dec_imm));
            disp_pc      = pc_q[head];
            disp_rd      = rd_eff;
            disp_pred    = pred_q[head];
            disp_val1    = opnd_val1;
            disp_val2    = opnd_val2;
            disp_tag1    = opnd_tag1;
            disp_tag2    = opnd_tag2;
            disp_rob_tag = rob_free_tag;
            ren_valid    = (rd_eff != 5'd0);
            ren_rd       = rd_eff;
            ren_tag      = rob_free_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
            end
        end
    end

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[tail] <= fetch_inst;
            pc_q[tail]   <= fetch_pc;
            pred_q[tail] <= fetch_pred;
        end
    end
endmodule

// decodeunit: RV32I field extraction and operation enumeration.
// Ports: inst in; op (0 = NOP for anything unrecognised), rd, rs1, rs2,
// and the sign-extended immediate for the instruction's format.
module decodeunit (
    input  logic [31:0] inst,
    output logic [5:0]  op,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm
);
    logic [6:0] opc, f7;
    logic [2:0] f3;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];
    assign rd  = inst[11:7];
    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];

    always_comb begin
        op  = 6'd0;
        imm = 32'h0;
        case (opc)
            7'b0110111: begin op = 6'd1; imm = {inst[31:12], 12'h0}; end
            7'b0010111: begin op = 6'd2; imm = {inst[31:12], 12'h0}; end
            7'b1101111: begin
                op  = 6'd3;
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            7'b1100111: begin
                if (f3 == 3'b000) op = 6'd4;
                imm = {{20{inst[31]}}, inst[31:20]};
            end
            7'b1100011: begin
                case (f3)
                    3'b000:  op = 6'd5;
                    3'b001:  op = 6'd6;
                    3'b100:  op = 6'd7;
                    3'b101:  op = 6'd8;
                    3'b110:  op = 6'd9;
                    3'b111:  op = 6'd10;
                    default: op = 6'd0;
                endcase
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b0000011: begin
                case (f3)
                    3'b000:  op = 6'd11;
                    3'b001:  op = 6'd12;
                    3'b010:  op = 6'd13;
                    3'b100:  op = 6'd14;
                    3'b101:  op = 6'd15;
                    default: op = 6'd0;
                endcase
                imm = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0100011: begin
                case (f3)
                    3'b000:  op = 6'd16;
                    3'b001:  op = 6'd17;
                    3'b010:  op = 6'd18;
                    default: op = 6'd0;
                endcase
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'b0010011: begin
                case (f3)
                    3'b000:  op = 6'd19;
                    3'b010:  op = 6'd20;
                    3'b011:  op = 6'd21;
                    3'b100:  op = 6'd22;
                    3'b110:  op = 6'd23;
                    3'b111:  op = 6'd24;
                    3'b001:  op = (f7 == 7'b0000000) ? 6'd25 : 6'd0;
                    default: op = (f7 == 7'b0000000) ? 6'd26 :
                                  (f7 == 7'b0100000) ? 6'd27 : 6'd0;
                endcase
                imm = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0110011: begin
                case ({f7, f3})
                    10'b0000000_000: op = 6'd28;
                    10'b0100000_000: op = 6'd29;
                    10'b0000000_001: op = 6'd30;
                    10'b0000000_010: op = 6'd31;
                    10'b0000000_011: op = 6'd32;
                    10'b0000000_100: op = 6'd33;
                    10'b0000000_101: op = 6'd34;
                    10'b0100000_101: op = 6'd35;
                    10'b0000000_110: op = 6'd36;
                    10'b0000000_111: op = 6'd37;
                    default:         op = 6'd0;
                endcase
            end
            default: op = 6'd0;
        endcase
    end
endmodule
